obi_mux_2_to_1: RTL

//  Two-master to one-slave OBI arbiter. Sits on the slave side of the crossbar, downstream of the 1-to-4 demuxes.

---
 rtl/obi_mux_2_to_1_if.sv | 18 +
 rtl/obi_mux_2_to_1.sv | 134 +++++++++++++
 2 files changed

// File: rtl/obi_mux_2_to_1_if.sv
// OBI address/response bundle shared by both master ports and the slave port
// of obi_mux_2_to_1. "master" drives the request side; "slave" answers it.
interface obi_mux_2_to_1_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req;
    logic                  gnt;
    logic [ADDR_W-1:0]     addr;
    logic                  we;
    logic [DATA_W/8-1:0]   be;
    logic [DATA_W-1:0]     wdata;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;

    modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/obi_mux_2_to_1.sv
// Two-master to one-slave OBI arbiter with a single outstanding read.
// Define OBI_MUX_RR_EN for round-robin arbitration; otherwise PRIO_MASTER wins ties.
module obi_mux_2_to_1 #(
    parameter int          ADDR_W      = 32,
    parameter int          DATA_W      = 32,
    parameter int unsigned PRIO_MASTER = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    obi_mux_2_to_1_if.slave  m1,
    obi_mux_2_to_1_if.slave  m2,
    obi_mux_2_to_1_if.master slv
);
    localparam logic [0:0] ST_IDLE      = 1'b0;
    localparam logic [0:0] ST_WAIT_RESP = 1'b1;

    // Master select encoding: 0 = master 1, 1 = master 2.
    localparam logic PRIO_SEL = (PRIO_MASTER == 32'd2) ? 1'b1 : 1'b0;

    logic [0:0] state_q, state_d;
    logic       owner_q, owner_d;
    logic       hold_vld_q, hold_vld_d;
    logic       hold_sel_q, hold_sel_d;
    logic       last_gnt_q, last_gnt_d;

    logic       arb_en_s;
    logic       winner_s;
    logic       sel_s;
    logic       sel_req_s;
    logic       sel_we_s;
    logic       slv_req_s;
    logic       accept_s;

    // Arbitration window and winner selection
    always_comb begin
        case (state_q)
            ST_IDLE:      arb_en_s = 1'b1;
            ST_WAIT_RESP: arb_en_s = slv.rvalid;
            default:      arb_en_s = 1'b0;
        endcase

        case ({m1.req, m2.req})
`ifdef OBI_MUX_RR_EN
            2'b11:   winner_s = ~last_gnt_q;
`else
            2'b11:   winner_s = PRIO_SEL;
`endif
            2'b10:   winner_s = 1'b0;
            2'b01:   winner_s = 1'b1;
            default: winner_s = PRIO_SEL;
        endcase

        // A presented but ungranted request keeps the bus until it is accepted.
        if (hold_vld_q) begin
            sel_s = hold_sel_q;
        end else begin
            sel_s = winner_s;
        end
    end

    // Address-phase routing towards the slave
    always_comb begin
        if (sel_s) begin
            sel_req_s = m2.req;
            sel_we_s  = m2.we;
            slv.addr  = m2.addr;
            slv.be    = m2.be;
            slv.wdata = m2.wdata;
        end else begin
            sel_req_s = m1.req;
            sel_we_s  = m1.we;
            slv.addr  = m1.addr;
            slv.be    = m1.be;
            slv.wdata = m1.wdata;
        end
        slv_req_s = arb_en_s & sel_req_s;
        accept_s  = slv_req_s & slv.gnt;
        slv.req   = slv_req_s;
        slv.we    = sel_we_s;
        m1.gnt    = arb_en_s & ~sel_s & slv.gnt;
        m2.gnt    = arb_en_s &  sel_s & slv.gnt;
    end

    // Read response steering to the owner of the outstanding read
    always_comb begin
        if (state_q == ST_WAIT_RESP) begin
            m1.rvalid = ~owner_q & slv.rvalid;
            m2.rvalid =  owner_q & slv.rvalid;
        end else begin
            m1.rvalid = 1'b0;
            m2.rvalid = 1'b0;
        end
        m1.rdata = slv.rdata;
        m2.rdata = slv.rdata;
    end

    // Next-state logic for transaction tracking
    always_comb begin
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        hold_vld_d = slv_req_s & ~slv.gnt;
        hold_sel_d = sel_s;
        if (accept_s) begin
            last_gnt_d = sel_s;
            if (!sel_we_s) begin
                state_d = ST_WAIT_RESP;
                owner_d = sel_s;
            end else begin
                state_d = ST_IDLE;
            end
        end else if ((state_q == ST_WAIT_RESP) && slv.rvalid) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_q;
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            owner_q    <= PRIO_SEL;
            hold_vld_q <= 1'b0;
            hold_sel_q <= PRIO_SEL;
            last_gnt_q <= ~PRIO_SEL;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            hold_vld_q <= hold_vld_d;
            hold_sel_q <= hold_sel_d;
            last_gnt_q <= last_gnt_d;
        end
    end
endmodule
